// File: rtl/mouse_packet_rx.sv
// -----------------------------------------------------------------------------
// mouse_packet_rx
//   PS/2 mouse protocol stage. It sits between the PS/2 byte transceiver and
//   the mouse consumers. After reset it asks the transceiver to send the
//   enable-streaming command (0xF4) and waits for the 0xFA acknowledge. It then
//   assembles 3-byte movement packets into signed 9-bit x/y deltas, button
//   bits and overflow flags, and announces each packet with a one-cycle tick.
//
// Parameters
//   TIMEOUT_CYCLES  idle cycles allowed mid-packet before resync (timeout build)
//   TO_W            idle counter width, 2**TO_W > TIMEOUT_CYCLES
//
// Configuration macro
//   MOUSE_RESYNC_TIMEOUT_EN  when defined, a stalled partial packet (idle in
//                            PKT2/PKT3 for TIMEOUT_CYCLES) is discarded and the
//                            receiver returns to PKT1 with a sync_err pulse.
//                            When undefined, resync relies only on the bit-3
//                            check of the first packet byte.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   rx_byte       in   received byte, valid with rx_done_tick
//   rx_done_tick  in   one-cycle pulse, new byte received
//   tx_done_tick  in   one-cycle pulse, command byte fully transmitted
//   wr_ps2        out  one-cycle request to transmit tx_data
//   tx_data       out  command byte, constant 0xF4
//   init_done     out  high once the ACK has been received
//   xm            out  x delta {b1[4], b2}
//   ym            out  y delta {b1[5], b3}
//   btnm          out  {middle, right, left} = b1[2:0]
//   ovf           out  {y_ovf, x_ovf} = b1[7:6]
//   m_done_tick   out  one-cycle pulse, new packet on xm/ym/btnm/ovf
//   sync_err      out  one-cycle pulse on a discarded byte/packet
//
// State table
//   INIT_SEND      | request transmission of the enable command
//   INIT_WAIT_TX   | wait for the transceiver to finish sending it
//   INIT_WAIT_ACK  | wait for 0xFA; any other byte is dropped
//   PKT1           | wait for packet byte 1 (bit 3 must be set)
//   PKT2           | wait for packet byte 2 (x delta low bits)
//   PKT3           | wait for packet byte 3 (y delta low bits)
//   DONE           | new packet presented, m_done_tick high
// -----------------------------------------------------------------------------
module mouse_packet_rx #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int TO_W           = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] tx_data,
  output logic       init_done,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic [1:0] ovf,
  output logic       m_done_tick,
  output logic       sync_err
);

  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] ACK_BYTE   = 8'hFA;

  // Reject a counter too narrow to hold the timeout terminal count.
  if (TIMEOUT_CYCLES < 2 || longint'(TIMEOUT_CYCLES) >= (longint'(1) << TO_W))
  begin : g_bad_timeout_cfg
    $error("mouse_packet_rx: TIMEOUT_CYCLES does not fit in TO_W bits");
  end

  typedef enum logic [2:0] {
    INIT_SEND     = 3'd0,
    INIT_WAIT_TX  = 3'd1,
    INIT_WAIT_ACK = 3'd2,
    PKT1          = 3'd3,
    PKT2          = 3'd4,
    PKT3          = 3'd5,
    DONE          = 3'd6
  } state_t;

  state_t     state_q, state_d;

  logic       wr_ps2_q, wr_ps2_d;
  logic       init_done_q, init_done_d;
  logic       sync_err_q, sync_err_d;

  // Byte 1 is kept as fields only; bit 3 is a framing bit and is not stored.
  logic       b1_xs_q, b1_xs_d;
  logic       b1_ys_q, b1_ys_d;
  logic [2:0] b1_btn_q, b1_btn_d;
  logic [1:0] b1_ovf_q, b1_ovf_d;
  logic [7:0] b2_q, b2_d;

  logic [8:0] xm_q, xm_d;
  logic [8:0] ym_q, ym_d;
  logic [2:0] btnm_q, btnm_d;
  logic [1:0] ovf_q, ovf_d;

  logic       timeout;
  logic       in_pkt;

  assign in_pkt = (state_q == PKT2) || (state_q == PKT3);

`ifdef MOUSE_RESYNC_TIMEOUT_EN
  // Idle down-counter: reloaded on every byte and whenever we are not
  // mid-packet, so reaching zero means TIMEOUT_CYCLES idle cycles in PKT2/PKT3.
  localparam logic [TO_W-1:0] IDLE_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q <= IDLE_LOAD;
    end else if (rx_done_tick || !in_pkt || timeout) begin
      idle_q <= IDLE_LOAD;
    end else begin
      idle_q <= idle_q - 1'b1;
    end
  end

  // A byte in the terminal cycle wins over the timeout.
  assign timeout = in_pkt && !rx_done_tick && (idle_q == '0);
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT_SEND;
      wr_ps2_q    <= 1'b0;
      init_done_q <= 1'b0;
      sync_err_q  <= 1'b0;
      b1_xs_q     <= 1'b0;
      b1_ys_q     <= 1'b0;
      b1_btn_q    <= '0;
      b1_ovf_q    <= '0;
      b2_q        <= '0;
      xm_q        <= '0;
      ym_q        <= '0;
      btnm_q      <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ps2_q    <= wr_ps2_d;
      init_done_q <= init_done_d;
      sync_err_q  <= sync_err_d;
      b1_xs_q     <= b1_xs_d;
      b1_ys_q     <= b1_ys_d;
      b1_btn_q    <= b1_btn_d;
      b1_ovf_q    <= b1_ovf_d;
      b2_q        <= b2_d;
      xm_q        <= xm_d;
      ym_q        <= ym_d;
      btnm_q      <= btnm_d;
      ovf_q       <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_SEND:     state_d = INIT_WAIT_TX;
      INIT_WAIT_TX:  if (tx_done_tick) state_d = INIT_WAIT_ACK;
      INIT_WAIT_ACK: if (rx_done_tick && (rx_byte == ACK_BYTE)) state_d = PKT1;
      PKT1:          if (rx_done_tick && rx_byte[3]) state_d = PKT2;
      PKT2: begin
        if (rx_done_tick)  state_d = PKT3;
        else if (timeout)  state_d = PKT1;
      end
      PKT3: begin
        if (rx_done_tick)  state_d = DONE;
        else if (timeout)  state_d = PKT1;
      end
      DONE:          state_d = PKT1;
      default:       state_d = INIT_SEND;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // wr_ps2 is registered so it is low during reset and pulses in the cycle
    // after INIT_SEND, exactly once.
    wr_ps2_d    = (state_q == INIT_SEND);
    init_done_d = init_done_q;
    sync_err_d  = 1'b0;
    b1_xs_d     = b1_xs_q;
    b1_ys_d     = b1_ys_q;
    b1_btn_d    = b1_btn_q;
    b1_ovf_d    = b1_ovf_q;
    b2_d        = b2_q;
    xm_d        = xm_q;
    ym_d        = ym_q;
    btnm_d      = btnm_q;
    ovf_d       = ovf_q;

    case (state_q)
      INIT_WAIT_ACK: begin
        if (rx_done_tick && (rx_byte == ACK_BYTE)) init_done_d = 1'b1;
      end
      PKT1: begin
        if (rx_done_tick) begin
          if (rx_byte[3]) begin
            b1_ovf_d = rx_byte[7:6];
            b1_ys_d  = rx_byte[5];
            b1_xs_d  = rx_byte[4];
            b1_btn_d = rx_byte[2:0];
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      PKT2: begin
        if (rx_done_tick)  b2_d       = rx_byte;
        else if (timeout)  sync_err_d = 1'b1;
      end
      PKT3: begin
        // Byte 3 goes straight into the output registers on the transition
        // into DONE, so the packet is visible in the same cycle as the tick.
        if (rx_done_tick) begin
          xm_d   = {b1_xs_q, b2_q};
          ym_d   = {b1_ys_q, rx_byte};
          btnm_d = b1_btn_q;
          ovf_d  = b1_ovf_q;
        end else if (timeout) begin
          sync_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign m_done_tick = (state_q == DONE);
  assign tx_data     = CMD_ENABLE;
  assign wr_ps2      = wr_ps2_q;
  assign init_done   = init_done_q;
  assign sync_err    = sync_err_q;
  assign xm          = xm_q;
  assign ym          = ym_q;
  assign btnm        = btnm_q;
  assign ovf         = ovf_q;

endmodule
